// File: rtl/lsu_pkg.sv
// Shared types, address map and byte-lane helpers for the handshaked load-store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b10,
    SZ_BYTE = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } lsu_state_e;

  localparam logic [15:0] REG_RAM = 16'h0000;
  localparam logic [15:0] REG_IO  = 16'h1000;
  localparam logic [15:0] REG_SW  = 16'h1001;

  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: be = 4'b0001 << addr;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Narrow store data is replicated so that every enabled lane sees the right bits.
  function automatic logic [31:0] wdata_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_HALF: lanes = {2{wdata[15:0]}};
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] addr,
                                               input logic uns, input logic [31:0] raw);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half   = addr[1] ? raw[31:16] : raw[15:0];
    byte_v = 8'(raw >> {addr, 3'b000});
    case (size)
      SZ_HALF: res = {{16{half[15] & ~uns}}, half};
      SZ_BYTE: res = {{24{byte_v[7] & ~uns}}, byte_v};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Single-port synchronous data RAM with per-byte write enables and one-cycle read latency.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int    DEPTH   = 16384,
  parameter string MEMFILE = ""
) (
  input  logic                     i_clk,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [3:0]               i_we,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane writes and registered read share one port.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    rdata_q <= mem_q[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/lsu_hs.sv
// Handshaked load-store unit: one request in flight against data RAM, output registers
// and synchronised switches, with misaligned/unmapped accesses reported as faults.
module lsu_hs
  import lsu_pkg::*;
#(
  parameter int    DMEM_DEPTH     = 16384,
  parameter int    NUM_IO         = 5,
  parameter int    SW_SYNC_STAGES = 2,
  parameter string MEMFILE        = ""
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [31:0]           i_req_addr,
  input  logic [31:0]           i_req_wdata,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_fault,
  output logic [32*NUM_IO-1:0]  o_io_out,
  input  logic [31:0]           i_io_sw
);

  localparam int AW = $clog2(DMEM_DEPTH);

  lsu_state_e  state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_fault_q;
  logic [31:0] io_q [NUM_IO];
  logic [31:0] io_d [NUM_IO];
  logic [31:0] sw_sync_q [SW_SYNC_STAGES];

  logic [15:0]   region;
  logic [3:0]    io_idx;
  logic          hit_ram, hit_io, hit_sw, misaligned, fault, commit;
  logic [3:0]    be;
  logic [31:0]   lanes, io_sel, raw, dmem_rdata;
  logic [3:0]    dmem_we;
  logic [AW-1:0] dmem_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = i_req_valid ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = i_rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (state_q)
      IDLE:    o_req_ready = 1'b1;
      RESP:    o_rsp_valid = 1'b1;
      default: o_req_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (state_q == IDLE && i_req_valid) begin
      we_q    <= i_req_we;
      uns_q   <= i_req_unsigned;
      size_q  <= i_req_size;
      addr_q  <= i_req_addr;
      wdata_q <= i_req_wdata;
    end
  end

  assign region     = addr_q[31:16];
  assign io_idx     = addr_q[15:12];
  assign hit_ram    = (region == REG_RAM);
  assign hit_io     = (region == REG_IO) && ({28'd0, io_idx} < 32'(NUM_IO));
  assign hit_sw     = (region == REG_SW) && !we_q;
  assign misaligned = ((size_q != SZ_HALF) && (size_q != SZ_BYTE) && (addr_q[1:0] != 2'b00))
                   || ((size_q == SZ_HALF) && addr_q[0]);
  assign fault      = misaligned || !(hit_ram || hit_io || hit_sw);
  // Reset during ACCESS must drop the store.
  assign commit     = (state_q == ACCESS) && we_q && !fault && !i_reset;
  assign be         = be_from_size(size_q, addr_q[1:0]);
  assign lanes      = wdata_lanes(size_q, wdata_q);

  // The RAM is read on the accept edge so its data is ready during ACCESS.
  assign dmem_addr = (state_q == IDLE) ? i_req_addr[AW+1:2] : addr_q[AW+1:2];
  assign dmem_we   = (commit && hit_ram) ? be : 4'b0000;

  lsu_dmem #(
    .DEPTH   (DMEM_DEPTH),
    .MEMFILE (MEMFILE)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_addr  (dmem_addr),
    .i_we    (dmem_we),
    .i_wdata (lanes),
    .o_rdata (dmem_rdata)
  );

  always_comb begin
    io_sel = 32'd0;
    for (int k = 0; k < NUM_IO; k++) begin
      io_sel = (io_idx == 4'(k)) ? io_q[k] : io_sel;
    end
    if (hit_ram)     raw = dmem_rdata;
    else if (hit_io) raw = io_sel;
    else             raw = sw_sync_q[SW_SYNC_STAGES-1];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_rdata_q <= 32'd0;
      rsp_fault_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      rsp_rdata_q <= (fault || we_q) ? 32'd0 : load_extract(size_q, addr_q[1:0], uns_q, raw);
      rsp_fault_q <= fault;
    end
  end

  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_fault = rsp_fault_q;

  always_comb begin
    for (int k = 0; k < NUM_IO; k++) begin
      for (int b = 0; b < 4; b++) begin
        io_d[k][8*b +: 8] = (commit && hit_io && (io_idx == 4'(k)) && be[b])
                          ? lanes[8*b +: 8] : io_q[k][8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_IO; k++) begin
      if (i_reset) io_q[k] <= 32'd0;
      else         io_q[k] <= io_d[k];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int s = 0; s < SW_SYNC_STAGES; s++) begin
      if (i_reset)     sw_sync_q[s] <= 32'd0;
      else if (s == 0) sw_sync_q[s] <= i_io_sw;
      else             sw_sync_q[s] <= sw_sync_q[s-1];
    end
  end

  always_comb begin
    o_io_out = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      o_io_out[32*k +: 32] = io_q[k];
    end
  end

endmodule

// File: tb/tb_lsu_hs.sv
// Scoreboard bench for lsu_hs: directed requests push expected responses, a monitor checks them.
module tb_lsu_hs;

  localparam int NUM_IO = 5;
  localparam logic [1:0] SW_ = 2'b00;
  localparam logic [1:0] SH_ = 2'b10;
  localparam logic [1:0] SB_ = 2'b11;

  logic                 clk = 1'b0;
  logic                 i_reset = 1'b1;
  logic                 i_req_valid = 1'b0;
  logic                 o_req_ready;
  logic                 i_req_we = 1'b0;
  logic [31:0]          i_req_addr = 32'd0;
  logic [31:0]          i_req_wdata = 32'd0;
  logic [1:0]           i_req_size = 2'b00;
  logic                 i_req_unsigned = 1'b0;
  logic                 o_rsp_valid;
  logic                 i_rsp_ready = 1'b1;
  logic [31:0]          o_rsp_rdata;
  logic                 o_rsp_fault;
  logic [32*NUM_IO-1:0] o_io_out;
  logic [31:0]          i_io_sw = 32'd0;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q [$];

  lsu_hs #(.DMEM_DEPTH(16384), .NUM_IO(NUM_IO), .SW_SYNC_STAGES(2), .MEMFILE("")) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_fault(o_rsp_fault), .o_io_out(o_io_out), .i_io_sw(i_io_sw)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, want);
    end
  endfunction

  // Monitor: every consumed response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!i_reset && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual rdata=0x%08h fault=%0b expected no response",
                 o_rsp_rdata, o_rsp_fault);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", o_rsp_rdata, e[31:0]);
        chk("rsp_fault", 32'(o_rsp_fault), 32'(e[32]));
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    chk("req_ready_idle", 32'(o_req_ready), 32'd1);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_addr     = addr;
    i_req_wdata    = wdata;
    i_req_size     = size;
    i_req_unsigned = uns;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] want_rd, input logic want_f);
    int n;
    drive(we, addr, wdata, size, uns);
    exp_q.push_back({want_f, want_rd});
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    chk("lat_access_no_valid", 32'(o_rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_resp_valid", 32'(o_rsp_valid), 32'd1);
    n = 0;
    while (o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_drained", 32'(o_rsp_valid), 32'd0);
  endtask

  task automatic chk_io(input string nm, input logic [31:0] reg2);
    for (int k = 0; k < NUM_IO; k++) begin
      chk(nm, o_io_out[32*k +: 32], (k == 2) ? reg2 : 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 32'(o_req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_rdata", o_rsp_rdata, 32'd0);
    chk("reset_fault", 32'(o_rsp_fault), 32'd0);
    chk_io("reset_io", 32'd0);

    // Word path and extension
    issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, SW_, 1'b0, 32'd0, 1'b0);
    issue(1'b0, 32'h0000_0100, 32'd0, SW_, 1'b0, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'h0000_0103, 32'd0, SB_, 1'b0, 32'hFFFF_FFDE, 1'b0);
    issue(1'b0, 32'h0000_0103, 32'd0, SB_, 1'b1, 32'h0000_00DE, 1'b0);
    issue(1'b0, 32'h0000_0100, 32'd0, SH_, 1'b0, 32'hFFFF_BEEF, 1'b0);
    issue(1'b0, 32'h0000_0102, 32'd0, SH_, 1'b1, 32'h0000_DEAD, 1'b0);

    // Partial IO store
    issue(1'b1, 32'h1000_2000, 32'h0000_0000, SW_, 1'b0, 32'd0, 1'b0);
    issue(1'b1, 32'h1000_2001, 32'h0000_007F, SB_, 1'b0, 32'd0, 1'b0);
    chk("io2_after_sb", o_io_out[95:64], 32'h0000_7F00);
    issue(1'b0, 32'h1000_2000, 32'd0, SW_, 1'b0, 32'h0000_7F00, 1'b0);

    // Faults leave RAM and IO untouched
    issue(1'b0, 32'h0000_0102, 32'd0, SW_, 1'b0, 32'd0, 1'b1);
    issue(1'b1, 32'h0000_0101, 32'h0000_1234, SH_, 1'b0, 32'd0, 1'b1);
    issue(1'b1, 32'h1001_0000, 32'hFFFF_FFFF, SW_, 1'b0, 32'd0, 1'b1);
    issue(1'b0, 32'h2000_0000, 32'd0, SW_, 1'b0, 32'd0, 1'b1);
    issue(1'b1, 32'h1000_5000, 32'h5555_5555, SW_, 1'b0, 32'd0, 1'b1);
    chk_io("io_after_faults", 32'h0000_7F00);
    issue(1'b0, 32'h0000_0100, 32'd0, SW_, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Switch synchroniser
    i_io_sw = 32'h0000_0A5A;
    repeat (3) @(negedge clk);
    issue(1'b0, 32'h1001_0000, 32'd0, SW_, 1'b0, 32'h0000_0A5A, 1'b0);
    i_io_sw = 32'h1234_5678;
    issue(1'b0, 32'h1001_0000, 32'd0, SW_, 1'b0, 32'h0000_0A5A, 1'b0);
    issue(1'b0, 32'h1001_0000, 32'd0, SW_, 1'b0, 32'h1234_5678, 1'b0);

    // Backpressure: response held stable while not consumed
    i_rsp_ready = 1'b0;
    drive(1'b0, 32'h0000_0100, 32'd0, SW_, 1'b0);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_rdata", o_rsp_rdata, 32'hDEAD_BEEF);
      chk("bp_fault", 32'(o_rsp_fault), 32'd0);
      chk("bp_req_ready", 32'(o_req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 i_rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_released", 32'(o_rsp_valid), 32'd0);

    // Reset during ACCESS of a store
    drive(1'b1, 32'h0000_0100, 32'h1111_2222, SW_, 1'b0);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    i_reset = 1'b1;
    @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("rst_access_ready", 32'(o_req_ready), 32'd1);
    chk_io("rst_access_io", 32'd0);
    repeat (3) begin
      chk("rst_access_no_rsp", 32'(o_rsp_valid), 32'd0);
      @(negedge clk);
    end
    issue(1'b0, 32'h0000_0100, 32'd0, SW_, 1'b0, 32'hDEAD_BEEF, 1'b0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
